irq_sched: RTL

//  Interrupt dispatch scheduler for the dcpirq interrupt controller. Latches one-cycle
//  irq_trigger pulses into a pending register and arbitrates among unmasked pending sources.

---
 rtl/irq_sched.sv | 108 ++++++++++
 1 files changed

// File: rtl/irq_sched.sv
// rtl/irq_sched.sv - interrupt dispatch scheduler: pending capture, arbitration, req/ack/eoi FSM
module irq_sched #(
   parameter int NUM_SRC = 4,
   parameter int VEC_W   = 2,
   parameter bit RR_EN   = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [NUM_SRC-1:0] irq_trigger,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               cpu_ack,
   input  logic               cpu_eoi,
   output logic               cpu_irq,
   output logic [VEC_W-1:0]   cpu_vec,
   output logic               in_service,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] overrun
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] SERV = 2'd2;

   logic [1:0]         state;
   logic [VEC_W-1:0]   rr_ptr;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] ack_clr;
   logic [VEC_W-1:0]   winner;
   logic               found;
   logic               acked;
   logic [VEC_W-1:0]   rr_next;
   int                 j;

   assign acked    = (state == REQ) && cpu_ack;
   assign ack_clr  = acked ? (NUM_SRC'(1) << cpu_vec) : '0;
   assign eligible = enable ? (pending & ~irq_mask) : '0;
   assign rr_next  = (cpu_vec == VEC_W'(NUM_SRC - 1)) ? '0 : cpu_vec + 1'b1;

   // Search starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      j      = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         j = (RR_EN ? int'(rr_ptr) : 0) + k;
         if (j >= NUM_SRC) j = j - NUM_SRC;
         if (!found && eligible[j]) begin
            found  = 1'b1;
            winner = VEC_W'(j);
         end
      end
   end

   // A trigger landing in the ack cycle re-arms the bit and is not an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         overrun <= '0;
      end else begin
         pending <= (pending & ~ack_clr) | irq_trigger;
         overrun <= irq_trigger & pending & ~ack_clr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cpu_irq    <= 1'b0;
         cpu_vec    <= '0;
         in_service <= 1'b0;
         rr_ptr     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  cpu_vec <= winner;
                  cpu_irq <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (cpu_ack) begin
                  cpu_irq    <= 1'b0;
                  in_service <= 1'b1;
                  state      <= SERV;
               end else if (!enable || irq_mask[cpu_vec]) begin
                  cpu_irq <= 1'b0;
                  state   <= IDLE;
               end
            end
            SERV: begin
               if (cpu_eoi) begin
                  in_service <= 1'b0;
                  rr_ptr     <= rr_next;
                  state      <= IDLE;
               end
            end
            default: begin
               cpu_irq    <= 1'b0;
               in_service <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
